// File: rtl/cobra_hex_display.sv
// Multiplexed 8-digit hex display driver for the CYBERcobra out_o word.
// One digit per SCAN_DIV-cycle slot, guard band at slot start, frame-aligned capture.
module cobra_hex_display #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned GUARD    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    input  logic        blank_lz_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int unsigned     DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      dig_q, dig_d;
    logic [31:0]     cap_q, cap_d;
    logic            first_q;
    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            tick;
    logic            active;
    logic [7:0]      blank;
    logic [3:0]      nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + 1'b1;
        dig_d = tick ? dig_q + 3'd1 : dig_q;

        // New word only enters at the digit-7 -> digit-0 boundary, so frames never mix words.
        cap_d = cap_q;
        if (!hold_i && (first_q || (tick && dig_q == 3'd7))) begin
            cap_d = data_i;
        end

        // Digit i is a leading zero when every nibble from i upward is zero.
        blank = '0;
        for (int i = 1; i < 8; i++) begin
            blank[i] = blank_lz_i && ((cap_q >> (4 * i)) == 32'd0);
        end

        nibble = cap_q[4*dig_q +: 4];
        active = (32'(div_q) >= GUARD) && !blank[dig_q];

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (active) begin
            an_d  = ~(8'b1 << dig_q);
            seg_d = hex7(nibble);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            dig_q   <= '0;
            cap_q   <= '0;
            first_q <= 1'b1;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
        end else begin
            div_q   <= div_d;
            dig_q   <= dig_d;
            cap_q   <= cap_d;
            first_q <= 1'b0;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule
